// File: rtl/apb_protocol_checker_pkg.sv
// ----------------------------------------------------------------------------
// apb_checker_pkg
// Shared types and helpers for the APB protocol checker:
//   apb_state_e   - tracking FSM states (IDLE / SETUP / ACCESS)
//   err_code_e    - error codes 1..11, lower value = higher priority
//   NUM_ERR       - number of error codes (width of the sticky vector)
//   err_bit()     - one-hot error-vector bit for a code (bit k-1 for code k)
//   err_priority()- lowest code present in an error vector (0 if none)
//   lowest_index()- index of the lowest set bit of a select vector
// ----------------------------------------------------------------------------
package apb_checker_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2
    } apb_state_e;

    typedef enum logic [3:0] {
        ERR_NONE            = 4'd0,
        ERR_PADDR_XZ        = 4'd1,
        ERR_PRWD_XZ         = 4'd2,
        ERR_PWDATA_XZ       = 4'd3,
        ERR_PENABLE_XZ      = 4'd4,
        ERR_PSEL_XZ         = 4'd5,
        ERR_MULTI_PSEL      = 4'd6,
        ERR_ENABLE_NO_SETUP = 4'd7,
        ERR_SETUP_NO_ACCESS = 4'd8,
        ERR_UNSTABLE        = 4'd9,
        ERR_TIMEOUT         = 4'd10,
        ERR_SLVERR          = 4'd11
    } err_code_e;

    localparam int NUM_ERR = 11;

    function automatic logic [NUM_ERR-1:0] err_bit(input err_code_e code);
        err_bit = NUM_ERR'(1) << (int'(code) - 1);
    endfunction

    // Scan from the top down so the lowest set code is the one left behind.
    function automatic logic [3:0] err_priority(input logic [NUM_ERR-1:0] vec);
        err_priority = 4'd0;
        for (int k = NUM_ERR - 1; k >= 0; k--) begin
            if (vec[k]) begin
                err_priority = 4'(k + 1);
            end
        end
    endfunction

    function automatic logic [4:0] lowest_index(input logic [31:0] vec);
        lowest_index = 5'd0;
        for (int k = 31; k >= 0; k--) begin
            if (vec[k]) begin
                lowest_index = 5'(k);
            end
        end
    endfunction

endpackage

// File: rtl/apb_protocol_checker_if.sv
// ----------------------------------------------------------------------------
// apb_protocol_checker_if
// APB bus bundle observed by the checker.
//   master  - drives request signals, receives pready/prdata/pslverr
//   slave   - mirror of master
//   monitor - read-only view used by the checker; prdata is left out
//             because the checker never inspects read data
// ----------------------------------------------------------------------------
interface apb_protocol_checker_if #(
    parameter int PADDR_WIDTH  = 32,
    parameter int PWDATA_WIDTH = 32,
    parameter int PRDATA_WIDTH = 32,
    parameter int NUM_SLAVES   = 16
);
    logic [PADDR_WIDTH-1:0]  paddr;
    logic                    prwd;
    logic [PWDATA_WIDTH-1:0] pwdata;
    logic                    penable;
    logic [NUM_SLAVES-1:0]   psel;
    logic                    pready;
    logic [PRDATA_WIDTH-1:0] prdata;
    logic                    pslverr;

    modport master (
        output paddr, prwd, pwdata, penable, psel,
        input  pready, prdata, pslverr
    );

    modport slave (
        input  paddr, prwd, pwdata, penable, psel,
        output pready, prdata, pslverr
    );

    modport monitor (
        input paddr, prwd, pwdata, penable, psel, pready, pslverr
    );
endinterface

// File: rtl/apb_protocol_checker_err_log.sv
// ----------------------------------------------------------------------------
// apb_chk_err_log
// Error/transfer bookkeeping behind the checker FSM.
//   clk, srst      - clock, synchronous active-high reset
//   err_vec        - errors found this cycle (bit k-1 = code k)
//   err_slave_in   - lowest active psel index this cycle
//   xfer_done      - a transfer completed this cycle
//   clear          - clear sticky flags and both counters
//   err_valid/err_code/err_slave - one-cycle error report
//   err_sticky     - accumulated error codes
//   err_count, xfer_count - saturating counters
// Inputs are first captured on the sampling edge, then folded into the
// outputs on the following edge, so a report appears one cycle after the
// offending sample. clear travels through the same stage, which is what
// lets a clear win over an error sampled on the same edge.
// ----------------------------------------------------------------------------
module apb_chk_err_log
    import apb_checker_pkg::*;
#(
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 srst,
    input  logic [NUM_ERR-1:0]   err_vec,
    input  logic [4:0]           err_slave_in,
    input  logic                 xfer_done,
    input  logic                 clear,
    output logic                 err_valid,
    output logic [3:0]           err_code,
    output logic [4:0]           err_slave,
    output logic [NUM_ERR-1:0]   err_sticky,
    output logic [CNT_WIDTH-1:0] err_count,
    output logic [CNT_WIDTH-1:0] xfer_count
);
    // capture stage
    logic [NUM_ERR-1:0]   vec_q;
    logic [4:0]           slave_q;
    logic                 xfer_q;
    logic                 clear_q;
    // report stage
    logic                 valid_q,  valid_d;
    logic [3:0]           code_q,   code_d;
    logic [4:0]           eslave_q, eslave_d;
    logic [NUM_ERR-1:0]   sticky_q, sticky_d;
    logic [CNT_WIDTH-1:0] ecnt_q,   ecnt_d;
    logic [CNT_WIDTH-1:0] xcnt_q,   xcnt_d;

    generate
        for (genvar gi = 0; gi < NUM_ERR; gi++) begin : g_sticky
            assign sticky_d[gi] = !clear_q && (sticky_q[gi] || vec_q[gi]);
        end
    endgenerate

    always_comb begin
        valid_d  = |vec_q;
        code_d   = err_priority(vec_q);
        eslave_d = valid_d ? slave_q : 5'd0;

        ecnt_d = ecnt_q;
        if (clear_q) begin
            ecnt_d = '0;
        end else if (valid_d && (ecnt_q != '1)) begin
            ecnt_d = ecnt_q + CNT_WIDTH'(1);
        end

        xcnt_d = xcnt_q;
        if (clear_q) begin
            xcnt_d = '0;
        end else if (xfer_q && (xcnt_q != '1)) begin
            xcnt_d = xcnt_q + CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            vec_q    <= '0;
            slave_q  <= '0;
            xfer_q   <= 1'b0;
            clear_q  <= 1'b0;
            valid_q  <= 1'b0;
            code_q   <= '0;
            eslave_q <= '0;
            sticky_q <= '0;
            ecnt_q   <= '0;
            xcnt_q   <= '0;
        end else begin
            vec_q    <= err_vec;
            slave_q  <= err_slave_in;
            xfer_q   <= xfer_done;
            clear_q  <= clear;
            valid_q  <= valid_d;
            code_q   <= code_d;
            eslave_q <= eslave_d;
            sticky_q <= sticky_d;
            ecnt_q   <= ecnt_d;
            xcnt_q   <= xcnt_d;
        end
    end

    assign err_valid  = valid_q;
    assign err_code   = code_q;
    assign err_slave  = eslave_q;
    assign err_sticky = sticky_q;
    assign err_count  = ecnt_q;
    assign xfer_count = xcnt_q;

endmodule

// File: rtl/apb_protocol_checker.sv
// ----------------------------------------------------------------------------
// apb_protocol_checker
// Passive APB checker: follows each transfer through IDLE/SETUP/ACCESS and
// flags X/Z, sequencing, stability, multi-select, timeout and slave errors.
//   pclock, preset - clock, synchronous active-high reset
//   has_checks     - 0 suppresses all reporting and parks the FSM in IDLE
//   err_clear      - clears sticky flags, err_count and xfer_count
//   bus            - monitored APB signals (monitor modport)
//   err_valid/err_code/err_slave - one-cycle report, one cycle after the
//                    offending sample
//   err_sticky, err_count, xfer_count - accumulated status
//   state          - current FSM state
// The FSM state reflects the phase of the sample just taken: SETUP means the
// setup cycle was seen and the next sample must be the first access cycle.
// ----------------------------------------------------------------------------
module apb_protocol_checker
    import apb_checker_pkg::*;
#(
    parameter int PADDR_WIDTH    = 32,
    parameter int PWDATA_WIDTH   = 32,
    parameter int PRDATA_WIDTH   = 32,
    parameter int NUM_SLAVES     = 16,
    parameter int TIMEOUT_CYCLES = 16,
    parameter int CNT_WIDTH      = 16
) (
    input  logic                   pclock,
    input  logic                   preset,
    input  logic                   has_checks,
    input  logic                   err_clear,
    apb_protocol_checker_if.monitor bus,
    output logic                   err_valid,
    output logic [3:0]             err_code,
    output logic [4:0]             err_slave,
    output logic [NUM_ERR-1:0]     err_sticky,
    output logic [CNT_WIDTH-1:0]   err_count,
    output logic [CNT_WIDTH-1:0]   xfer_count,
    output logic [1:0]             state
);
    localparam int WAIT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT_CYCLES - 1);

    apb_state_e              state_q, state_d;
    logic [PADDR_WIDTH-1:0]  cap_paddr_q, cap_paddr_d;
    logic                    cap_prwd_q, cap_prwd_d;
    logic [PWDATA_WIDTH-1:0] cap_pwdata_q, cap_pwdata_d;
    logic [NUM_SLAVES-1:0]   cap_psel_q, cap_psel_d;
    logic [WAIT_W-1:0]       wait_q, wait_d;

    logic [NUM_ERR-1:0]      err_vec;
    logic                    xfer_done;
    logic                    psel_active;
    logic                    multi_sel;
    logic                    same_req;
    logic [4:0]              sel_index;

    assign sel_index = lowest_index(32'(bus.psel));

    always_comb begin
        state_d      = state_q;
        cap_paddr_d  = cap_paddr_q;
        cap_prwd_d   = cap_prwd_q;
        cap_pwdata_d = cap_pwdata_q;
        cap_psel_d   = cap_psel_q;
        wait_d       = '0;
        err_vec      = '0;
        xfer_done    = 1'b0;

        psel_active = |bus.psel;
        multi_sel   = |(bus.psel & (bus.psel - NUM_SLAVES'(1)));
        // Write data only has to hold for writes; reads may toggle pwdata.
        same_req    = (bus.paddr == cap_paddr_q) && (bus.prwd == cap_prwd_q) &&
                      (bus.psel == cap_psel_q) &&
                      (!cap_prwd_q || (bus.pwdata == cap_pwdata_q));

`ifndef SYNTHESIS
        if (psel_active && $isunknown(bus.paddr))            err_vec |= err_bit(ERR_PADDR_XZ);
        if (psel_active && $isunknown(bus.prwd))             err_vec |= err_bit(ERR_PRWD_XZ);
        if (psel_active && bus.prwd && $isunknown(bus.pwdata)) err_vec |= err_bit(ERR_PWDATA_XZ);
        if ($isunknown(bus.penable))                         err_vec |= err_bit(ERR_PENABLE_XZ);
        if ($isunknown(bus.psel))                            err_vec |= err_bit(ERR_PSEL_XZ);
`endif
        if (multi_sel) begin
            err_vec |= err_bit(ERR_MULTI_PSEL);
        end

        case (state_q)
            ST_IDLE: begin
                if (psel_active) begin
                    if (bus.penable) begin
                        err_vec |= err_bit(ERR_ENABLE_NO_SETUP);
                    end else if (!multi_sel) begin
                        // A multi-select has no single target; do not track it.
                        state_d      = ST_SETUP;
                        cap_paddr_d  = bus.paddr;
                        cap_prwd_d   = bus.prwd;
                        cap_pwdata_d = bus.pwdata;
                        cap_psel_d   = bus.psel;
                    end
                end
            end
            ST_SETUP: begin
                state_d = ST_IDLE;
                if (!bus.penable || (bus.psel != cap_psel_q)) begin
                    err_vec |= err_bit(ERR_SETUP_NO_ACCESS);
                end else if (!same_req) begin
                    err_vec |= err_bit(ERR_UNSTABLE);
                end else if (bus.pready) begin
                    // Zero-wait transfer: the first access cycle completes it.
                    xfer_done = 1'b1;
                    if (bus.pslverr) err_vec |= err_bit(ERR_SLVERR);
                end else begin
                    state_d = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                state_d = ST_IDLE;
                if (!bus.penable || !same_req) begin
                    err_vec |= err_bit(ERR_UNSTABLE);
                end else if (bus.pready) begin
                    xfer_done = 1'b1;
                    if (bus.pslverr) err_vec |= err_bit(ERR_SLVERR);
                end else if (wait_q >= WAIT_LAST) begin
                    err_vec |= err_bit(ERR_TIMEOUT);
                end else begin
                    state_d = ST_ACCESS;
                    wait_d  = wait_q + WAIT_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (!has_checks) begin
            err_vec   = '0;
            xfer_done = 1'b0;
            state_d   = ST_IDLE;
            wait_d    = '0;
        end
    end

    always_ff @(posedge pclock) begin
        if (preset) begin
            state_q      <= ST_IDLE;
            cap_paddr_q  <= '0;
            cap_prwd_q   <= 1'b0;
            cap_pwdata_q <= '0;
            cap_psel_q   <= '0;
            wait_q       <= '0;
        end else begin
            state_q      <= state_d;
            cap_paddr_q  <= cap_paddr_d;
            cap_prwd_q   <= cap_prwd_d;
            cap_pwdata_q <= cap_pwdata_d;
            cap_psel_q   <= cap_psel_d;
            wait_q       <= wait_d;
        end
    end

    assign state = state_q;

    apb_chk_err_log #(
        .CNT_WIDTH (CNT_WIDTH)
    ) u_err_log (
        .clk          (pclock),
        .srst         (preset),
        .err_vec      (err_vec),
        .err_slave_in (sel_index),
        .xfer_done    (xfer_done),
        .clear        (err_clear),
        .err_valid    (err_valid),
        .err_code     (err_code),
        .err_slave    (err_slave),
        .err_sticky   (err_sticky),
        .err_count    (err_count),
        .xfer_count   (xfer_count)
    );

endmodule
